// File: rtl/seq_mem_d1_pipe_be.sv
// Word-addressed synchronous memory with byte-enable writes, a parameterised read
// pipeline, done pulses and sticky collision / out-of-bounds error flags.
module seq_mem_d1_pipe_be #(
   parameter int WIDTH        = 32,
   parameter int SIZE         = 8,
   parameter int IDX_SIZE     = 4,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [IDX_SIZE-1:0]   addr0,
   input  logic                  read_en,
   output logic [WIDTH-1:0]      out,
   output logic                  read_done,
   input  logic [WIDTH-1:0]      in,
   input  logic                  write_en,
   input  logic [WIDTH/8-1:0]    byte_en,
   output logic                  write_done,
   input  logic                  err_clr,
   output logic                  err_collision,
   output logic                  err_oob
);

   localparam int NBYTES = WIDTH / 8;
   localparam int AW     = (SIZE > 1) ? $clog2(SIZE) : 1;
   localparam logic [IDX_SIZE:0] SIZE_L = (IDX_SIZE + 1)'(SIZE);

   if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_badLatency
      $error("seq_mem_d1_pipe_be: READ_LATENCY must be in 1..4");
   end
   if (WIDTH % 8 != 0 || WIDTH < 8) begin : g_badWidth
      $error("seq_mem_d1_pipe_be: WIDTH must be a non-zero multiple of 8");
   end
   if ((2 ** IDX_SIZE) < SIZE) begin : g_badIdx
      $error("seq_mem_d1_pipe_be: IDX_SIZE too small for SIZE");
   end

   logic [WIDTH-1:0] r_mem [SIZE];
   logic             r_pipeVld [READ_LATENCY];
   logic [WIDTH-1:0] r_pipeDat [READ_LATENCY];
   logic             r_writeDone;
   logic             r_errCollision;
   logic             r_errOob;

   logic             w_inRange;
   logic [AW-1:0]    w_idx;
   logic             w_wrAcc;
   logic             w_rdAcc;
   logic             w_collision;
   logic             w_oob;

   assign w_inRange   = ({1'b0, addr0} < SIZE_L);
   assign w_idx       = addr0[AW-1:0];
   assign w_wrAcc     = write_en & w_inRange & reset_n;
   assign w_rdAcc     = read_en & ~write_en & w_inRange;
   assign w_collision = read_en & write_en;
   assign w_oob       = (read_en | write_en) & ~w_inRange;

   // Storage is deliberately not reset; contents survive reset_n.
   always_ff @(posedge clk) begin
      if (w_wrAcc) begin
         for (int k = 0; k < NBYTES; k++) begin
            if (byte_en[k]) begin
               r_mem[w_idx][8*k +: 8] <= in[8*k +: 8];
            end
         end
      end
   end

   // Data in each stage only advances with a valid word, so the last stage holds
   // the most recent read result and doubles as the out register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int s = 0; s < READ_LATENCY; s++) begin
            r_pipeVld[s] <= 1'b0;
            r_pipeDat[s] <= '0;
         end
      end else begin
         r_pipeVld[0] <= w_rdAcc;
         if (w_rdAcc) begin
            r_pipeDat[0] <= r_mem[w_idx];
         end
         for (int s = 1; s < READ_LATENCY; s++) begin
            r_pipeVld[s] <= r_pipeVld[s-1];
            if (r_pipeVld[s-1]) begin
               r_pipeDat[s] <= r_pipeDat[s-1];
            end
         end
      end
   end

   // A new error in the same cycle as err_clr still leaves the flag set.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_writeDone    <= 1'b0;
         r_errCollision <= 1'b0;
         r_errOob       <= 1'b0;
      end else begin
         r_writeDone    <= w_wrAcc;
         r_errCollision <= w_collision | (r_errCollision & ~err_clr);
         r_errOob       <= w_oob | (r_errOob & ~err_clr);
      end
   end

   assign out           = r_pipeDat[READ_LATENCY-1];
   assign read_done     = r_pipeVld[READ_LATENCY-1];
   assign write_done    = r_writeDone;
   assign err_collision = r_errCollision;
   assign err_oob       = r_errOob;

endmodule

// File: doc/seq_mem_d1_pipe_be.md
SEQ_MEM_D1_PIPE_BE -- requirements
Module: seq_mem_d1_pipe_be

Interface
REQ-001 Parameters SHALL be, one per line:
  WIDTH, 32, data width in bits; multiple of 8.
  SIZE, 8, number of words.
  IDX_SIZE, 4, address width; 2**IDX_SIZE >= SIZE.
  READ_LATENCY, 1, cycles from read accept to out/read_done; legal range 1..4.
REQ-002 Ports SHALL be, one per line (name  direction  width  meaning):
  clk  in  1  single clock; all state updates on its rising edge.
  reset_n  in  1  asynchronous active-low reset.
  addr0  in  IDX_SIZE  word address for read or write.
  read_en  in  1  read request, one word per asserted cycle.
  out  out  WIDTH  registered read data.
  read_done  out  1  one-cycle pulse, out valid this cycle.
  in  in  WIDTH  write data.
  write_en  in  1  write request.
  byte_en  in  WIDTH/8  per-byte write mask; bit k covers in[8k+7:8k].
  write_done  out  1  one-cycle pulse, cycle after an accepted write.
  err_clr  in  1  synchronous clear of sticky error flags.
  err_collision  out  1  sticky: read_en and write_en asserted together.
  err_oob  out  1  sticky: access with addr0 >= SIZE.

Function
REQ-003 Write accept: write_en=1 and addr0<SIZE SHALL update mem[addr0] bytes whose byte_en bit is 1 at that edge; other bytes unchanged.
REQ-004 write_done SHALL be 1 exactly the cycle after each accepted write, else 0.
REQ-005 Read accept: read_en=1, write_en=0, addr0<SIZE SHALL capture mem[addr0] as of that edge (pre-write contents) into a READ_LATENCY-deep pipeline.
REQ-006 out SHALL take the captured word and read_done SHALL pulse exactly READ_LATENCY cycles after the accepting edge; back-to-back reads SHALL yield one result per cycle, in order.
REQ-007 out SHALL hold its last read value until the next read result emerges; writes SHALL NOT alter or clobber out.
REQ-008 Collision (read_en=1, write_en=1): write SHALL proceed per REQ-003; read SHALL be dropped (no read_done); err_collision SHALL set on next edge.
REQ-009 Out-of-bounds (addr0>=SIZE with read_en or write_en): access SHALL be suppressed, no memory change, no done pulse; err_oob SHALL set on next edge.
REQ-010 Error flags SHALL stay set until err_clr=1 or reset; if err_clr and a new error occur in the same cycle, flag SHALL be 1 after the edge (set wins).
REQ-011 A write and an in-flight read pipeline SHALL be independent: a write to an address already read does not change the queued result.
REQ-012 Read of a never-written word SHALL return an unspecified value; bench SHALL not check it.
REQ-013 READ_LATENCY outside 1..4 or WIDTH not a multiple of 8 SHALL be an elaboration-time error.

Reset
REQ-014 reset_n=0 SHALL asynchronously force out=0, read_done=0, write_done=0, err_collision=0, err_oob=0 and flush every read-pipeline stage.
REQ-015 Memory contents SHALL NOT be reset; reads issued before reset SHALL never produce read_done after reset.
REQ-016 reset_n deassertion SHALL be honoured synchronously; first accepted access is the first rising edge with reset_n=1.

Verification (WIDTH=32, SIZE=8, IDX_SIZE=4, READ_LATENCY=2 unless stated)
REQ-017 Write 0xDEADBEEF to addr 3 byte_en=4'hF, then read addr 3 -> write_done pulse next cycle; out=0xDEADBEEF with read_done exactly 2 cycles after read accept.
REQ-018 Then write 0x11223344 to addr 3 byte_en=4'b0101, read addr 3 -> out=0xDE22BE44; out holds 0xDEADBEEF through the write cycle.
REQ-019 Reads of addr 0,1,2 on consecutive cycles (preloaded 0xA,0xB,0xC) -> read_done high 3 consecutive cycles, out=0xA,0xB,0xC in order.
REQ-020 read_en=1,write_en=1 addr 5 data 0x55 -> mem[5]=0x55, write_done pulses, no read_done, err_collision=1 until err_clr; write addr 9 -> err_oob=1, no write_done, mem unchanged.
REQ-021 Issue read then assert reset_n=0 one cycle later -> all outputs 0 immediately, no read_done after release; prior memory contents readable unchanged.
REQ-022 Repeat REQ-017 and REQ-019 with READ_LATENCY=1 and 4 -> read_done latency 1 and 4 respectively.
